// File: rtl/parallel_to_serial.sv
// parallel_to_serial: accepts WIDTH-bit words over valid/ready, buffers one
// word, and streams each word LSB-first on sEEG, one bit per clk cycle.
// frameStart marks bit 0 of every word; consecutive words are gapless when
// the producer keeps the holding register filled.
module parallel_to_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] eegIn,
  input  logic             inValid,
  output logic             inReady,
  output logic             sEEG,
  output logic             sValid,
  output logic             frameStart,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_holdFull;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bitCnt;
  logic             r_sValid;
  logic             r_frameStart;

  // next-state values and decode
  state_t           w_state;
  logic [WIDTH-1:0] w_hold;
  logic             w_holdFull;
  logic [WIDTH-1:0] w_shreg;
  logic [CW-1:0]    w_bitCnt;
  logic             w_sValid;
  logic             w_frameStart;
  logic             w_accept;
  logic             w_lastBit;
  logic             w_load;

  // Ready drops during reset so nothing is accepted on a reset edge.
  assign inReady    = !r_holdFull && !rst;
  // shreg is cleared whenever the line goes idle, so bit 0 is already 0 then.
  assign sEEG       = r_shreg[0];
  assign sValid     = r_sValid;
  assign frameStart = r_frameStart;
  assign busy       = (r_state == SHIFT) || r_holdFull;

  // Next-state logic: handshake, load/reload, shifting and end-of-word.
  always_comb begin
    w_state      = r_state;
    w_hold       = r_hold;
    w_holdFull   = r_holdFull;
    w_shreg      = r_shreg;
    w_bitCnt     = r_bitCnt;
    w_sValid     = r_sValid;
    w_frameStart = r_frameStart;

    w_accept  = inValid && inReady;
    w_lastBit = (r_state == SHIFT) && (r_bitCnt == LAST);
    // A reload at the last bit wins over returning to IDLE, so no gap appears.
    w_load    = r_holdFull && ((r_state == IDLE) || w_lastBit);

    case (r_state)
      IDLE: begin
        w_sValid     = 1'b0;
        w_frameStart = 1'b0;
        if (w_load) begin
          w_state      = SHIFT;
          w_shreg      = r_hold;
          w_bitCnt     = '0;
          w_sValid     = 1'b1;
          w_frameStart = 1'b1;
        end
      end
      SHIFT: begin
        if (w_load) begin
          w_shreg      = r_hold;
          w_bitCnt     = '0;
          w_sValid     = 1'b1;
          w_frameStart = 1'b1;
        end else if (w_lastBit) begin
          w_state      = IDLE;
          w_shreg      = '0;
          w_bitCnt     = '0;
          w_sValid     = 1'b0;
          w_frameStart = 1'b0;
        end else begin
          w_shreg      = r_shreg >> 1;
          w_bitCnt     = r_bitCnt + CW'(1);
          w_frameStart = 1'b0;
        end
      end
      default: begin
        w_state      = IDLE;
        w_shreg      = '0;
        w_bitCnt     = '0;
        w_sValid     = 1'b0;
        w_frameStart = 1'b0;
      end
    endcase

    // Accept and drain are mutually exclusive: accept needs an empty hold,
    // a load needs a full one.
    if (w_accept) begin
      w_hold     = eegIn;
      w_holdFull = 1'b1;
    end else if (w_load) begin
      w_holdFull = 1'b0;
    end
  end

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_holdFull   <= 1'b0;
      r_shreg      <= '0;
      r_bitCnt     <= '0;
      r_sValid     <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hold       <= w_hold;
      r_holdFull   <= w_holdFull;
      r_shreg      <= w_shreg;
      r_bitCnt     <= w_bitCnt;
      r_sValid     <= w_sValid;
      r_frameStart <= w_frameStart;
    end
  end

endmodule
